// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous RAM between the video
// fetch path and two game-logic requesters (A, B).
//   clk, rst                 pixel clock, synchronous active-high reset
//   hpos, active             timing generator position / visible flag
//   vid_addr -> vid_data     tile fetch address, last fetched word
//   vid_valid                pulse: vid_data just updated
//   x_req/we/addr/wdata      requester A/B access (level, held until x_gnt)
//   x_gnt                    pulse: access issued to RAM this cycle
//   x_rvalid, x_rdata        pulse + registered read data
//   mem_en/we/addr/wdata     registered RAM command, mem_rdata returns a cycle later
// Video slots (active && hpos mod VID_PERIOD == 0) always win; other cycles
// go round-robin between A and B. A tag travels with each access so read data
// is steered to the right result register two edges after the grant.
module vram_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int VID_PERIOD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        hpos,
  input  logic              active,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int SLOT_W = $clog2(VID_PERIOD);

  // Destination of read data; writes travel as TAG_NONE.
  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_A, TAG_B} tag_e;

  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic              last_a_q, last_a_d;   // 1: last A/B grant went to A
  // tag_pipe_q[0]: command on mem_* now; [1]: RAM returning its data now
  tag_e              tag_pipe_q [2];
  tag_e              tag_pipe_d [2];
  logic              vid_valid_q, vid_valid_d, a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d, a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic slot, a_elig, b_elig, pick_a, pick_b;
  logic unused_hpos;

  assign unused_hpos = ^hpos[9:SLOT_W];

  always_comb begin
    slot   = active && (hpos[SLOT_W-1:0] == '0);
    // A requester whose grant is showing this cycle is still holding req
    // for that same access; masking it prevents a double grant.
    a_elig = a_req && !a_gnt_q;
    b_elig = b_req && !b_gnt_q;
    pick_a = a_elig && (!b_elig || !last_a_q);
    pick_b = b_elig && !pick_a;

    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    a_gnt_d       = 1'b0;
    b_gnt_d       = 1'b0;
    last_a_d      = last_a_q;
    tag_pipe_d[0] = TAG_NONE;
    tag_pipe_d[1] = tag_pipe_q[0];

    if (slot) begin
      mem_en_d      = 1'b1;
      mem_addr_d    = vid_addr;
      tag_pipe_d[0] = TAG_VID;
    end else if (pick_a) begin
      mem_en_d      = 1'b1;
      mem_we_d      = a_we;
      mem_addr_d    = a_addr;
      if (a_we) mem_wdata_d = a_wdata;
      a_gnt_d       = 1'b1;
      last_a_d      = 1'b1;
      tag_pipe_d[0] = a_we ? TAG_NONE : TAG_A;
    end else if (pick_b) begin
      mem_en_d      = 1'b1;
      mem_we_d      = b_we;
      mem_addr_d    = b_addr;
      if (b_we) mem_wdata_d = b_wdata;
      b_gnt_d       = 1'b1;
      last_a_d      = 1'b0;
      tag_pipe_d[0] = b_we ? TAG_NONE : TAG_B;
    end

    // Result stage: each register loads only for its own tag.
    vid_valid_d = (tag_pipe_q[1] == TAG_VID);
    a_rvalid_d  = (tag_pipe_q[1] == TAG_A);
    b_rvalid_d  = (tag_pipe_q[1] == TAG_B);
    vid_data_d  = vid_valid_d ? mem_rdata : vid_data_q;
    a_rdata_d   = a_rvalid_d  ? mem_rdata : a_rdata_q;
    b_rdata_d   = b_rvalid_d  ? mem_rdata : b_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      a_gnt_q       <= 1'b0;
      b_gnt_q       <= 1'b0;
      last_a_q      <= 1'b0;
      tag_pipe_q[0] <= TAG_NONE;
      tag_pipe_q[1] <= TAG_NONE;
      vid_valid_q   <= 1'b0;
      a_rvalid_q    <= 1'b0;
      b_rvalid_q    <= 1'b0;
      vid_data_q    <= '0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
    end else begin
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      a_gnt_q       <= a_gnt_d;
      b_gnt_q       <= b_gnt_d;
      last_a_q      <= last_a_d;
      tag_pipe_q[0] <= tag_pipe_d[0];
      tag_pipe_q[1] <= tag_pipe_d[1];
      vid_valid_q   <= vid_valid_d;
      a_rvalid_q    <= a_rvalid_d;
      b_rvalid_q    <= b_rvalid_d;
      vid_data_q    <= vid_data_d;
      a_rdata_q     <= a_rdata_d;
      b_rdata_q     <= b_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign a_gnt     = a_gnt_q;
  assign b_gnt     = b_gnt_q;
  assign vid_valid = vid_valid_q;
  assign vid_data  = vid_data_q;
  assign a_rvalid  = a_rvalid_q;
  assign a_rdata   = a_rdata_q;
  assign b_rvalid  = b_rvalid_q;
  assign b_rdata   = b_rdata_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural synchronous RAM, a vector table for the
// A/B request/grant/read-back path, and short hand sequences for video slots,
// round-robin, slot blocking, reset mid-access and single-grant behaviour.
module tb_vram_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hpos;
  logic       active;
  logic [7:0] vid_addr, vid_data;
  logic       vid_valid;
  logic       a_req, a_we, a_gnt, a_rvalid;
  logic [7:0] a_addr, a_wdata, a_rdata;
  logic       b_req, b_we, b_gnt, b_rvalid;
  logic [7:0] b_addr, b_wdata, b_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  vram_arbiter #(.ADDR_W(8), .DATA_W(8), .VID_PERIOD(8)) dut (
    .clk(clk), .rst(rst), .hpos(hpos), .active(active),
    .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM; ram_init preloads 0xA5 at 0x03.
  logic       ram_init;
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= (i == 3) ? 8'hA5 : 8'h00;
      mem_rdata <= 8'h00;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct {
    logic       a_req, a_we;
    logic [7:0] a_addr, a_wdata;
    logic       b_req, b_we;
    logic [7:0] b_addr, b_wdata;
    logic       e_agnt, e_bgnt, e_en, e_we;
    logic [7:0] e_addr;
    logic       e_arv;
    logic [7:0] e_ard;
    logic       e_brv;
    logic [7:0] e_brd;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_en"}, int'(mem_en), 0);
    chk({tag, ".mem_we"}, int'(mem_we), 0);
    chk({tag, ".mem_addr"}, int'(mem_addr), 0);
    chk({tag, ".mem_wdata"}, int'(mem_wdata), 0);
    chk({tag, ".a_gnt"}, int'(a_gnt), 0);
    chk({tag, ".b_gnt"}, int'(b_gnt), 0);
    chk({tag, ".a_rvalid"}, int'(a_rvalid), 0);
    chk({tag, ".b_rvalid"}, int'(b_rvalid), 0);
    chk({tag, ".vid_valid"}, int'(vid_valid), 0);
    chk({tag, ".vid_data"}, int'(vid_data), 0);
    chk({tag, ".a_rdata"}, int'(a_rdata), 0);
    chk({tag, ".b_rdata"}, int'(b_rdata), 0);
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    int n_gnt, n_en;
    rst = 1; ram_init = 1; active = 0; hpos = 0; vid_addr = 8'h03;
    idle_inputs();
    tick();
    ram_init = 0;
    tick();
    chk_all_zero("reset");
    rst = 0;

    // Video slots: hpos value presented before each edge.
    active = 1;
    for (int h = 0; h < 20; h++) begin
      hpos = 10'(h);
      tick();
      chk($sformatf("vid.mem_en.h%0d", h), int'(mem_en), int'(h % 8 == 0));
      if (h % 8 == 0) chk($sformatf("vid.mem_addr.h%0d", h), int'(mem_addr), 'h03);
      chk($sformatf("vid.valid.h%0d", h), int'(vid_valid), int'(h >= 2 && (h - 2) % 8 == 0));
      if (h >= 2 && (h - 2) % 8 == 0) chk($sformatf("vid.data.h%0d", h), int'(vid_data), 'hA5);
    end
    active = 0; hpos = 1;
    tick();
    tick();

    // Table: A write/read, B write, A/B contention and read-back.
    tbl[0] = '{1,1,8'h12,8'h5A, 0,0,8'h00,8'h00, 1,0,1,1,8'h12, 0,8'h00, 0,8'h00};
    tbl[1] = '{1,1,8'h12,8'h5A, 0,0,8'h00,8'h00, 0,0,0,0,8'h12, 0,8'h00, 0,8'h00};
    tbl[2] = '{1,0,8'h12,8'h00, 0,0,8'h00,8'h00, 1,0,1,0,8'h12, 0,8'h00, 0,8'h00};
    tbl[3] = '{0,0,8'h00,8'h00, 1,1,8'h40,8'hC3, 0,1,1,1,8'h40, 0,8'h00, 0,8'h00};
    tbl[4] = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,8'h40, 1,8'h5A, 0,8'h00};
    tbl[5] = '{1,0,8'h03,8'h00, 1,0,8'h40,8'h00, 1,0,1,0,8'h03, 0,8'h00, 0,8'h00};
    tbl[6] = '{1,0,8'h03,8'h00, 1,0,8'h40,8'h00, 0,1,1,0,8'h40, 0,8'h00, 0,8'h00};
    tbl[7] = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,8'h40, 1,8'hA5, 0,8'h00};
    tbl[8] = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,8'h40, 0,8'h00, 1,8'hC3};
    for (int i = 0; i < 9; i++) begin
      a_req = tbl[i].a_req; a_we = tbl[i].a_we; a_addr = tbl[i].a_addr; a_wdata = tbl[i].a_wdata;
      b_req = tbl[i].b_req; b_we = tbl[i].b_we; b_addr = tbl[i].b_addr; b_wdata = tbl[i].b_wdata;
      tick();
      chk($sformatf("tbl%0d.a_gnt", i), int'(a_gnt), int'(tbl[i].e_agnt));
      chk($sformatf("tbl%0d.b_gnt", i), int'(b_gnt), int'(tbl[i].e_bgnt));
      chk($sformatf("tbl%0d.mem_en", i), int'(mem_en), int'(tbl[i].e_en));
      chk($sformatf("tbl%0d.mem_we", i), int'(mem_we), int'(tbl[i].e_we));
      chk($sformatf("tbl%0d.mem_addr", i), int'(mem_addr), int'(tbl[i].e_addr));
      chk($sformatf("tbl%0d.a_rvalid", i), int'(a_rvalid), int'(tbl[i].e_arv));
      chk($sformatf("tbl%0d.b_rvalid", i), int'(b_rvalid), int'(tbl[i].e_brv));
      if (tbl[i].e_arv) chk($sformatf("tbl%0d.a_rdata", i), int'(a_rdata), int'(tbl[i].e_ard));
      if (tbl[i].e_brv) chk($sformatf("tbl%0d.b_rdata", i), int'(b_rdata), int'(tbl[i].e_brd));
      if (tbl[i].e_we && tbl[i].e_agnt) chk($sformatf("tbl%0d.wdata", i), int'(mem_wdata), int'(tbl[i].a_wdata));
      if (tbl[i].e_we && tbl[i].e_bgnt) chk($sformatf("tbl%0d.wdata", i), int'(mem_wdata), int'(tbl[i].b_wdata));
    end

    // Round-robin from reset: both held, expect A,B,A,B...
    do_reset();
    a_req = 1; a_we = 0; a_addr = 8'h12;
    b_req = 1; b_we = 0; b_addr = 8'h40;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("rr%0d.a_gnt", k), int'(a_gnt), int'(k % 2 == 0));
      chk($sformatf("rr%0d.b_gnt", k), int'(b_gnt), int'(k % 2 == 1));
    end
    idle_inputs();
    tick();
    tick();
    tick();

    // A request first sampled at slot edge hpos=8 waits one edge.
    active = 1;
    for (int h = 4; h < 13; h++) begin
      hpos = 10'(h);
      a_req = (h == 8 || h == 9); a_we = 0; a_addr = 8'h12;
      tick();
      chk($sformatf("slot.a_gnt.h%0d", h), int'(a_gnt), int'(h == 9));
      chk($sformatf("slot.mem_en.h%0d", h), int'(mem_en), int'(h == 8 || h == 9));
      if (h == 8) chk("slot.vid_addr", int'(mem_addr), 'h03);
      if (h == 9) chk("slot.a_addr", int'(mem_addr), 'h12);
      chk($sformatf("slot.vid_valid.h%0d", h), int'(vid_valid), int'(h == 10));
      if (h == 10) chk("slot.vid_data", int'(vid_data), 'hA5);
      chk($sformatf("slot.a_rvalid.h%0d", h), int'(a_rvalid), int'(h == 11));
      if (h == 11) chk("slot.a_rdata", int'(a_rdata), 'h5A);
    end
    active = 0; hpos = 1;
    idle_inputs();
    tick();

    // Reset right after an A read grant: no rvalid, pointer back to A.
    a_req = 1; a_we = 0; a_addr = 8'h12;
    tick();
    chk("rst.pre_gnt", int'(a_gnt), 1);
    idle_inputs();
    rst = 1;
    tick();
    chk_all_zero("rst_mid");
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst.a_rvalid%0d", k), int'(a_rvalid), 0);
    end
    // Leave A as the last winner, then reset: both requesting must still grant A.
    a_req = 1; a_addr = 8'h12;
    tick();
    chk("rst.pre_a", int'(a_gnt), 1);
    idle_inputs();
    do_reset();
    a_req = 1; a_addr = 8'h12; b_req = 1; b_addr = 8'h40;
    tick();
    chk("rst.first_a", int'(a_gnt), 1);
    chk("rst.first_b", int'(b_gnt), 0);
    idle_inputs();
    tick();
    tick();
    tick();

    // Single A request held through its grant cycle: one grant, one access.
    n_gnt = 0; n_en = 0;
    a_req = 1; a_we = 1; a_addr = 8'h20; a_wdata = 8'h77;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_gnt += int'(a_gnt);
      n_en  += int'(mem_en);
      if (k == 1) a_req = 0;
    end
    chk("single.gnts", n_gnt, 1);
    chk("single.mem_en", n_en, 1);
    chk("single.wdata", int'(mem_wdata), 'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
